// File: rtl/instr_encoder_pkg.sv
// Shared core package for the RV32I encoder and the main decoder.
// Holds the instruction class codes, the nine base opcodes and the
// control-flag decode so that encoder and decoder stay in lockstep.
package instr_encoder_pkg;

    // Instruction class codes carried on in_class; 9..15 are illegal.
    typedef enum logic [3:0] {
        CLS_LW    = 4'd0,
        CLS_SW    = 4'd1,
        CLS_RTYPE = 4'd2,
        CLS_BR    = 4'd3,
        CLS_IALU  = 4'd4,
        CLS_JAL   = 4'd5,
        CLS_JALR  = 4'd6,
        CLS_LUI   = 4'd7,
        CLS_AUIPC = 4'd8
    } instr_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Main-decoder control flags derived from an opcode.
    typedef struct packed {
        logic regWrite;
        logic memWrite;
        logic branch;
        logic jump;
        logic jalr;
    } ctrl_t;

    // Opcode to control flags, as used by the main decoder.
    function automatic ctrl_t decodeControl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_LOAD:   c.regWrite = 1'b1;
            OP_STORE:  c.memWrite = 1'b1;
            OP_RTYPE:  c.regWrite = 1'b1;
            OP_BRANCH: c.branch   = 1'b1;
            OP_IALU:   c.regWrite = 1'b1;
            OP_JAL:    begin c.regWrite = 1'b1; c.jump = 1'b1; end
            OP_JALR:   begin c.regWrite = 1'b1; c.jalr = 1'b1; end
            OP_LUI:    c.regWrite = 1'b1;
            OP_AUIPC:  c.regWrite = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_format_pack.sv
// Combinational RV32I format packer.
// Ports:
//   cls     - instruction class code
//   rd/rs1/rs2, funct3, funct7 - register and function fields
//   imm     - signed immediate (byte units for branch/jal, unshifted for lui/auipc)
//   instr   - packed 32-bit instruction word
//   legal   - high when cls names one of the nine supported classes
module instr_format_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    // One format per class; unused fields of each format are simply not
    // referenced. Shift-immediate ALU ops (funct3 001/101) carry funct7
    // in the top bits and a 5-bit shift amount.
    always_comb begin
        instr = '0;
        legal = 1'b1;
        case (cls)
            CLS_LW:    instr = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            CLS_SW:    instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
            CLS_RTYPE: instr = {funct7, rs2, rs1, funct3, rd, OP_RTYPE};
            CLS_BR:    instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                                imm[4:1], imm[11], OP_BRANCH};
            CLS_IALU: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    instr = {funct7, imm[4:0], rs1, funct3, rd, OP_IALU};
                else
                    instr = {imm[11:0], rs1, funct3, rd, OP_IALU};
            end
            CLS_JAL:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            CLS_JALR:  instr = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            CLS_LUI:   instr = {imm[31:12], rd, OP_LUI};
            CLS_AUIPC: instr = {imm[31:12], rd, OP_AUIPC};
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder feeding an instruction-memory
// write port through a one-entry valid/ready output register.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   in_valid/in_ready  - request handshake
//   in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm - request
//   out_valid/out_ready - emitted-word handshake
//   out_instr, out_addr - encoded word and its byte write address
//   err                - sticky illegal-class flag
//   count              - words emitted, saturating
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [15:0] count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] wordIndex;
    logic [31:0]      packedWord;
    logic             packedLegal;
    logic             accept;
    logic             emit;

    instr_format_pack formatPack (
        .cls    (in_class),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (packedWord),
        .legal  (packedLegal)
    );

    // The output register can take a new word when empty or when its
    // current word leaves this cycle, which gives one word per cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;

    // The index always points at the held (or next) word, so the address
    // is a pure function of registered state.
    assign out_addr = BASE_ADDR + {{(30 - IDX_W){1'b0}}, wordIndex, 2'b00};

    // Handshake register, word index, sticky error and emitted-word count.
    // An accepted legal request overrides the clear from an emit so that
    // back-to-back words leave no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            wordIndex <= '0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            if (emit) begin
                wordIndex <= wordIndex + 1'b1;
                if (count != 16'hFFFF)
                    count <= count + 16'd1;
            end
            if (accept && packedLegal) begin
                out_valid <= 1'b1;
                out_instr <= packedWord;
            end else if (emit) begin
                out_valid <= 1'b0;
            end
            if (accept && !packedLegal)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard testbench for instr_encoder: stimulus pushes expected words,
// an independent monitor pops and compares them on each output handshake.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam logic [31:0] OPS [9] = '{32'h03, 32'h23, 32'h33, 32'h63, 32'h13,
                                        32'h6F, 32'h67, 32'h37, 32'h17};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_class = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [15:0] count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        int          cls;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   seqNum = 0;
    int   expCount = 0;
    int   hsCount = 0;
    logic expErr = 1'b0;
    bit   randomReady = 1'b0;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .count     (count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Random consumer backpressure, active only in the random phase.
    initial forever begin
        @(posedge clk);
        #1;
        if (randomReady)
            out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference encoder built from field positions with shifts and masks.
    function automatic logic [31:0] refEncode(input int cls,
            input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
            input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] lowImm;
        lowImm = imm & 32'hFFF;
        w = 0;
        case (cls)
            0: w = (lowImm << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7);
            1: w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15)
                   | (32'd2 << 12) | ((imm & 31) << 7);
            2: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7);
            3: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25)
                   | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
            4: if (f3 == 1 || f3 == 5)
                   w = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7);
               else
                   w = (lowImm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7);
            5: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7);
            6: w = (lowImm << 20) | (rs1 << 15) | (rd << 7);
            7, 8: w = (imm & 32'hFFFFF000) | (rd << 7);
            default: w = 0;
        endcase
        if (cls >= 0 && cls <= 8)
            w = w | OPS[cls];
        return w;
    endfunction

    // Expected main-decoder flags {regWrite, memWrite, branch, jump, jalr}.
    function automatic logic [31:0] expCtrl(input int cls);
        case (cls)
            1:       return 32'b01000;
            3:       return 32'b00100;
            5:       return 32'b10010;
            6:       return 32'b10001;
            default: return 32'b10000;
        endcase
    endfunction

    // Drive a request, wait (bounded) for acceptance, record the expectation.
    task automatic applyStimulusWord(input int cls, input logic [31:0] rd,
            input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
            input logic [31:0] f7, input logic [31:0] imm, input logic [31:0] expWord);
        bit got;
        int waited;
        exp_t e;
        in_class  = cls[3:0];
        in_rd     = rd[4:0];
        in_rs1    = rs1[4:0];
        in_rs2    = rs2[4:0];
        in_funct3 = f3[2:0];
        in_funct7 = f7[6:0];
        in_imm    = imm;
        in_valid  = 1'b1;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 100) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            waited++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL accept timeout: in_ready stayed 0, expected 1");
        end else if (cls <= 8) begin
            e.instr = expWord;
            e.addr  = BASE + 32'(4 * (seqNum % DEPTH));
            e.cls   = cls;
            sb.push_back(e);
            seqNum++;
        end else begin
            expErr = 1'b1;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int cls, input logic [31:0] rd,
            input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
            input logic [31:0] f7, input logic [31:0] imm);
        applyStimulusWord(cls, rd, rs1, rs2, f3, f7, imm,
                          refEncode(cls, rd, rs1, rs2, f3, f7, imm));
    endtask

    task automatic applyRandom(input int cls);
        applyStimulus(cls, $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 7),
                      $urandom_range(0, 127), $urandom);
    endtask

    task automatic doReset();
        sb.delete();
        seqNum = 0;
        expCount = 0;
        expErr = 1'b0;
        reset = 1'b1;
    endtask

    // Monitor: pops one expectation per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checkOutput("count", 32'(count), 32'(expCount));
                checkOutput("err", 32'(err), 32'(expErr));
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious word: got %h, expected no word", out_instr);
                    end else if (out_ready) begin
                        e = sb.pop_front();
                        checkOutput("instr", out_instr, e.instr);
                        checkOutput("addr", out_addr, e.addr);
                        checkOutput("loopback ctrl",
                                    32'(decodeControl(out_instr[6:0])), expCtrl(e.cls));
                        expCount++;
                        hsCount++;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] expA;
        logic [31:0] aAddr;
        int hs0;
        int cls;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst in_ready", 32'(in_ready), 1);
        checkOutput("rst out_valid", 32'(out_valid), 0);
        checkOutput("rst out_instr", out_instr, 0);
        checkOutput("rst out_addr", out_addr, BASE);
        checkOutput("rst err", 32'(err), 0);
        checkOutput("rst count", 32'(count), 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Directed encodings with known words.
        applyStimulusWord(0, 5, 2, 0, 0, 0, 8, 32'h00812283);
        applyStimulusWord(2, 3, 1, 2, 0, 0, 0, 32'h002081B3);
        applyStimulusWord(3, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFE000EE3);
        applyStimulusWord(5, 1, 0, 0, 0, 0, 8, 32'h008000EF);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: one word held stable for 5 cycles, then no gaps.
        out_ready = 1'b0;
        expA  = refEncode(4, 7, 3, 0, 0, 0, 32'h123);
        aAddr = BASE + 32'(4 * (seqNum % DEPTH));
        applyStimulus(4, 7, 3, 0, 0, 0, 32'h123);
        fork
            applyStimulus(1, 0, 4, 9, 0, 0, 32'h7F5);
            begin
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("bp in_ready", 32'(in_ready), 0);
                    checkOutput("bp out_valid", 32'(out_valid), 1);
                    checkOutput("bp out_instr", out_instr, expA);
                    checkOutput("bp out_addr", out_addr, aAddr);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        hs0 = hsCount;
        fork
            begin
                applyStimulus(4, 2, 6, 0, 3'b101, 7'b0100000, 32'h0000_0013);
                applyStimulus(6, 1, 5, 0, 0, 0, 32'hFFFF_F800);
            end
            begin
                repeat (3) @(negedge clk);
                #1 checkOutput("no bubble handshakes", 32'(hsCount - hs0), 3);
            end
        join

        // Reset while a word is held.
        @(posedge clk);
        #1 out_ready = 1'b0;
        applyStimulus(12, 0, 0, 0, 0, 0, 0);
        applyStimulus(7, 9, 0, 0, 0, 0, 32'hABCDE123);
        @(negedge clk);
        checkOutput("held before reset", 32'(out_valid), 1);
        #2 doReset();
        #1;
        checkOutput("mid rst out_valid", 32'(out_valid), 0);
        checkOutput("mid rst out_instr", out_instr, 0);
        checkOutput("mid rst out_addr", out_addr, BASE);
        checkOutput("mid rst err", 32'(err), 0);
        checkOutput("mid rst count", 32'(count), 0);
        checkOutput("mid rst in_ready", 32'(in_ready), 1);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Illegal class: no word, err set, index unchanged.
        applyStimulus(12, 1, 1, 1, 1, 1, 32'h55);
        repeat (2) begin
            @(negedge clk);
            checkOutput("illegal out_valid", 32'(out_valid), 0);
            checkOutput("illegal out_addr", out_addr, BASE);
        end
        checkOutput("illegal err", 32'(err), 1);
        @(posedge clk);
        #1;

        // Wrap: six words across a four-word window.
        for (int i = 0; i < 6; i++)
            applyRandom(i % 9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("wrap count", 32'(count), 6);
        checkOutput("wrap err sticky", 32'(err), 1);

        // Random traffic with random backpressure and idle gaps.
        @(posedge clk);
        #1 randomReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cls = $urandom_range(0, 10);
            if (cls > 8)
                cls = $urandom_range(9, 15);
            applyRandom(cls);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #2;
        randomReady = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("drain scoreboard", 32'(sb.size()), 0);
        checkOutput("drain out_valid", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first emitted instruction word.
REQ-002 Parameter DEPTH, default 256, number of instruction words in the write window; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request accepted this cycle when high together with in_valid.
REQ-007 in_class  input  4  0 lw, 1 sw, 2 R-type, 3 branch, 4 I-type ALU, 5 jal, 6 jalr, 7 lui, 8 auipc; 9-15 are illegal.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 in_funct3  input  3; in_funct7  input  7  function fields.
REQ-010 in_imm  input  32  signed immediate, in byte units for branch and jal, unshifted upper value for lui and auipc.
REQ-011 out_valid  output  1  encoded word held.
REQ-012 out_ready  input  1  consumer (instruction-memory write port) takes the word.
REQ-013 out_instr  output  32  encoded RV32I word.
REQ-014 out_addr  output  32  byte write address of out_instr.
REQ-015 err  output  1  sticky illegal-class flag.
REQ-016 count  output  16  number of words emitted, saturating at 16'hFFFF.

Function
REQ-017 in_ready = !out_valid || out_ready, combinational; no other combinational path from inputs to outputs.
REQ-018 On an accepted legal request, the encoded word is registered and out_valid is high the next cycle; latency is 1 cycle.
REQ-019 out_instr, out_addr and out_valid are held stable while out_valid && !out_ready.
REQ-020 On out_valid && out_ready, the word index increments; if no new request is accepted in that cycle, out_valid clears.
REQ-021 A simultaneous emit and accept loads the new word with no bubble, giving full throughput of one word per cycle.
REQ-022 out_addr = BASE_ADDR + 4*index, where the index is log2(DEPTH) bits wide and wraps from DEPTH-1 to 0.
REQ-023 Opcodes: lw 0000011, sw 0100011, R-type 0110011, branch 1100011, I-type ALU 0010011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
REQ-024 Encoding uses standard RV32I formats.
  - lw: I-type, funct3 forced to 010.
  - sw: S-type, funct3 forced to 010.
  - R-type: R-type with in_funct7 and in_funct3.
  - branch: B-type using in_imm[12:1].
  - I-type ALU: I-type using in_imm[11:0]; for funct3 001 or 101, bits[31:25] = in_funct7 and bits[24:20] = in_imm[4:0].
  - jal: J-type using in_imm[20:1].
  - jalr: I-type, funct3 forced to 000.
  - lui and auipc: U-type using in_imm[31:12].
REQ-025 Fields the selected format does not use are ignored; in_imm[0] is ignored for branch and jal.
REQ-026 An illegal class is accepted (in_ready unaffected), produces no word, does not advance the index, and sets err.
REQ-027 err clears only on reset.
REQ-028 count increments on each out_valid && out_ready handshake.

Reset
REQ-029 Asserting reset immediately forces the following values:
  - out_valid = 0, out_instr = 32'h0000_0000
  - index = 0, so out_addr = BASE_ADDR
  - err = 0, count = 0
REQ-030 A word held when reset asserts mid-operation is discarded; after deassertion the next word is written at BASE_ADDR.
REQ-031 in_ready is high during reset.

Structure
REQ-032 The class codes and the nine opcode constants belong in the shared core package, shared with the main decoder so that encoder and decoder cannot diverge.
REQ-033 One combinational sub-module, instr_format_pack, maps class, fields and immediate to the 32-bit word; the top holds the handshake register, index and counters.

Verification
REQ-034 Encoding: lw class, rd=5, rs1=2, imm=8 -> 0x00812283 at BASE_ADDR; R-type, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x002081B3 at BASE_ADDR+4.
REQ-035 Branch and jal: branch, rs1=0, rs2=0, funct3=0, imm=-4 -> 0xFE000EE3; jal, rd=1, imm=8 -> 0x008000EF.
REQ-036 Backpressure: out_ready low for 5 cycles with in_valid high -> exactly one word held stable, in_ready low; after release, consecutive words emitted with no gap.
REQ-037 Wrap: DEPTH=4, 6 requests -> addresses 0,4,8,12,0,4; count=6.
REQ-038 Illegal and reset: class 12 -> no out_valid, err=1, index unchanged; reset asserted while out_valid=1 -> out_valid=0, err=0, next word at BASE_ADDR.
REQ-039 Loopback: each emitted opcode fed to the main decoder yields that class's RegWrite, MemWrite, Branch, Jump and Jalr values.
